// File: rtl/softmax_stream_adapter.sv
// rtl/softmax_stream_adapter.sv - packs element-serial Q5.10 scores into rows for softmax_processor and re-serialises results
// Optional drained-row sum check: define SMX_SUMCHECK_EN (adds SUM_TOL parameter and drives err_sum).
module softmax_stream_adapter #(
   parameter int VEC_LEN      = 16,
   parameter int DATA_W       = 16,
   parameter int MAX_INFLIGHT = 4
`ifdef SMX_SUMCHECK_EN
   ,
   parameter int SUM_TOL      = 32
`endif
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [DATA_W-1:0]           s_data,
   input  logic                        s_last,
   output logic                        sm_valid_in,
   output logic [VEC_LEN*DATA_W-1:0]   sm_vector,
   input  logic                        sm_valid_out,
   input  logic [VEC_LEN*DATA_W-1:0]   sm_result,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [DATA_W-1:0]           m_data,
   output logic                        m_last,
   output logic                        busy,
   output logic                        err_framing,
   output logic                        err_overflow,
   output logic                        err_sum
);
   localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
   localparam int ROW_W = VEC_LEN * DATA_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_INFLIGHT - 1);
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(MAX_INFLIGHT);

   typedef enum logic {COLLECT, ISSUE} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [ROW_W-1:0] pack_row, pack_row_nxt;
   logic [CNT_W-1:0] credits, credits_nxt, rows;
   logic [PTR_W-1:0] wptr, rptr;
   logic [ROW_W-1:0] row_mem [MAX_INFLIGHT];
   logic             s_fire, m_fire, release_row, capture, issue_nxt;

   assign s_fire      = s_valid && s_ready;
   assign m_fire      = m_valid && m_ready;
   assign release_row = m_fire && (rd_idx == LAST_IDX);
   assign capture     = sm_valid_out && (rows != FULL);

   // Next-state lookahead lets sm_valid_in stay a register while still firing in the
   // first ISSUE cycle that has a credit, including a credit released on the previous edge.
   always_comb begin
      pack_row_nxt = pack_row;
      if (s_fire)
         pack_row_nxt[wr_idx*DATA_W +: DATA_W] = s_data;
      state_nxt = state;
      if (state == COLLECT && s_fire && wr_idx == LAST_IDX)
         state_nxt = ISSUE;
      if (sm_valid_in)
         state_nxt = COLLECT;
      credits_nxt = credits - CNT_W'(sm_valid_in) + CNT_W'(release_row);
      issue_nxt   = (state_nxt == ISSUE) && (credits_nxt != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= COLLECT;
         wr_idx       <= '0;
         pack_row     <= '0;
         sm_vector    <= '0;
         sm_valid_in  <= 1'b0;
         s_ready      <= 1'b0;
         credits      <= FULL;
         rows         <= '0;
         wptr         <= '0;
         rptr         <= '0;
         rd_idx       <= '0;
         err_framing  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         state       <= state_nxt;
         credits     <= credits_nxt;
         s_ready     <= (state_nxt == COLLECT);
         sm_valid_in <= issue_nxt;
         pack_row    <= pack_row_nxt;
         if (issue_nxt)
            sm_vector <= pack_row_nxt;
         if (s_fire) begin
            wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
            if (s_last != (wr_idx == LAST_IDX))
               err_framing <= 1'b1;
         end
         if (sm_valid_out) begin
            if (rows == FULL)
               err_overflow <= 1'b1;
            else
               wptr <= (wptr == LAST_PTR) ? '0 : wptr + PTR_W'(1);
         end
         rows <= rows + CNT_W'(capture) - CNT_W'(release_row);
         if (m_fire) begin
            if (rd_idx == LAST_IDX) begin
               rd_idx <= '0;
               rptr   <= (rptr == LAST_PTR) ? '0 : rptr + PTR_W'(1);
            end else begin
               rd_idx <= rd_idx + IDX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && capture)
         row_mem[wptr] <= sm_result;
   end

   assign m_valid = (rows != '0);
   assign m_data  = m_valid ? row_mem[rptr][rd_idx*DATA_W +: DATA_W] : '0;
   assign m_last  = m_valid && (rd_idx == LAST_IDX);
   assign busy    = (state == ISSUE) || (wr_idx != '0) || (credits != FULL);

`ifdef SMX_SUMCHECK_EN
   localparam int SUM_W = DATA_W + IDX_W;
   logic [SUM_W-1:0] acc, acc_nxt;
   int               row_sum;

   assign acc_nxt = acc + SUM_W'(m_data);
   assign row_sum = int'(acc_nxt);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         err_sum <= 1'b0;
      end else if (m_fire) begin
         if (m_last) begin
            acc <= '0;
            if (row_sum > 1024 + SUM_TOL || row_sum < 1024 - SUM_TOL)
               err_sum <= 1'b1;
         end else begin
            acc <= acc_nxt;
         end
      end
   end
`else
   assign err_sum = 1'b0;
`endif
endmodule
